acc_sequencer: RTL and testbench
================================

Name: acc_sequencer

Overview:
- Multi-cycle control stage that sits directly upstream of the 4-bit ALU and the shift/count register, and drives both.
- Accepts one instruction per valid/ready handshake and decodes it.
- Sequences the register's strobes (cl, ld, inc, dec, sr, sl, ir, il) and the ALU opcode/operand over one or more cycles.
- Pulses done when the instruction has retired.
- Makes the ALU + register pair a minimal accumulator datapath.

Parameters:
- WIDTH, 4, datapath width; ALU operand/result and register width.
- INSTR_W, WIDTH+4, instruction width; fixed relation, not to be overridden.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous, active-low reset
- instr  input  INSTR_W  instruction {cls[INSTR_W-1], fn[INSTR_W-2:INSTR_W-4], arg[WIDTH-1:0]}
- instr_valid  input  1  instruction offered
- instr_ready  output  1  sequencer can accept
- acc  input  WIDTH  current register output (feedback)
- alu_f  input  WIDTH  ALU result
- alu_oc  output  3  ALU opcode
- alu_a  output  WIDTH  ALU operand a (= acc)
- alu_b  output  WIDTH  ALU operand b
- reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il  output  1 each  register control strobes
- reg_in  output  WIDTH  register parallel load data
- busy  output  1  instruction in flight
- done  output  1  one-cycle retire pulse

Behaviour:
- States: IDLE, EXEC, DONE. Outputs are Moore decodes of the registered state and the latched instruction. Latched fields: cls, fn, arg, plus a 4-bit repeat counter cnt.
- Reset (rst_n low at a clk edge), including mid-instruction:
  - state to IDLE; cnt and latched instruction to 0.
  - Every strobe, done and busy read 0; alu_oc = 0; alu_b = 0; reg_in = 0.
  - instr_ready = 0 while rst_n is low and 1 in the first cycle after release.
  - An instruction in flight is abandoned; no further strobes.
- IDLE:
  - instr_ready = 1, busy = 0.
  - On instr_valid & instr_ready: latch instr, load cnt = arg[3:0] (zero-extended if WIDTH < 4), go to EXEC.
  - Exception: a repeat-class instruction with cnt = 0, or NOP, goes straight to DONE.
  - instr_valid while not ready is ignored; the source must hold it.
- EXEC: instr_ready = 0, busy = 1. Exactly one register strobe per cycle, never two.
  - cls = 1, ALU op, one cycle:
    - alu_oc = fn, alu_a = acc, alu_b = arg.
    - reg_ld = 1, reg_in = alu_f.
    - Next state DONE.
  - cls = 0, fn = 000 NOP: never enters EXEC.
  - cls = 0, fn = 001 LDI: reg_ld = 1, reg_in = arg; one cycle; next DONE.
  - cls = 0, fn = 010 CLR: reg_cl = 1; one cycle; next DONE.
  - cls = 0, fn = 011 INC×cnt: reg_inc = 1.
  - cls = 0, fn = 100 DEC×cnt: reg_dec = 1.
  - cls = 0, fn = 101 SHR×cnt: reg_sr = 1, reg_ir = 0.
  - cls = 0, fn = 110 SHL×cnt: reg_sl = 1, reg_il = 0.
  - cls = 0, fn = 111 ROR×cnt: reg_sr = 1, reg_ir = acc[0] (sampled combinationally each cycle).
  - Repeat classes (011–111): each EXEC cycle decrements cnt. When cnt = 1 the next state is DONE, so exactly cnt strobe cycles are issued.
- DONE:
  - done = 1 for exactly one cycle, busy = 1, instr_ready = 0, all strobes 0.
  - Next state IDLE.
- Latency, accept edge to done cycle:
  - ALU/LDI/CLR: 2 cycles.
  - Repeat ops: cnt + 1 cycles.
  - NOP and cnt = 0: 1 cycle.
- Back-to-back throughput: one instruction per (latency + 1) cycles; no accept in the DONE cycle.
- Outside EXEC: alu_oc = latched fn, alu_b = latched arg, reg_in = 0.
- Arithmetic wrap is the ALU/register's concern; the sequencer never modifies data.

Test Plan:
- Reset then LDI 4'h5 (instr 8'h15): ready=1 one cycle after reset release; accept; next cycle reg_ld=1, reg_in=5; following cycle done=1; register reads 5.
- ALU op instr 8'hA3 with acc=5: EXEC cycle alu_oc=3'b010, alu_a=5, alu_b=3, reg_ld=1, reg_in=alu_f; done two cycles after accept.
- INC×3 (8'h33) from acc=14: reg_inc high exactly 3 consecutive cycles; register wraps 14→15→0→1; done on 4th cycle; no other strobe ever high.
- ROR×1 (8'h71) with acc=4'b0011: reg_sr=1, reg_ir=1 → register 4'b1001; SHL×0 (8'h60): done next cycle, zero strobes.
- rst_n driven low during the 2nd cycle of DEC×5: all strobes 0 from that edge; state IDLE; instr_ready=1 after release; done never pulses for the aborted instruction.
- instr_valid held high with varied instr while busy: no new accept until IDLE; instruction present at the accept edge executes exactly once.

Source files
------------

// File: rtl/acc_sequencer.sv
// Control stage for the ALU + shift/count register pair: accepts one instruction
// per handshake and sequences the register strobes and ALU controls until retire.
module acc_sequencer #(
  parameter  int WIDTH   = 4,
  localparam int INSTR_W = WIDTH + 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]   alu_f,
  output logic [2:0]         alu_oc,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic               reg_cl,
  output logic               reg_ld,
  output logic               reg_inc,
  output logic               reg_dec,
  output logic               reg_sr,
  output logic               reg_ir,
  output logic               reg_sl,
  output logic               reg_il,
  output logic [WIDTH-1:0]   reg_in,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [2:0] FN_NOP = 3'b000;
  localparam logic [2:0] FN_LDI = 3'b001;
  localparam logic [2:0] FN_CLR = 3'b010;
  localparam logic [2:0] FN_INC = 3'b011;
  localparam logic [2:0] FN_DEC = 3'b100;
  localparam logic [2:0] FN_SHR = 3'b101;
  localparam logic [2:0] FN_SHL = 3'b110;
  localparam logic [2:0] FN_ROR = 3'b111;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             cls_r;
  logic [2:0]       fn_r;
  logic [WIDTH-1:0] arg_r;
  logic [3:0]       cnt_r;

  logic             in_cls_s;
  logic [2:0]       in_fn_s;
  logic [WIDTH-1:0] in_arg_s;
  logic [3:0]       in_cnt_s;
  logic             accept_s;
  logic             skip_exec_s;

  assign in_cls_s = instr[INSTR_W-1];
  assign in_fn_s  = instr[INSTR_W-2:INSTR_W-4];
  assign in_arg_s = instr[WIDTH-1:0];
  assign in_cnt_s = 4'(in_arg_s);
  assign accept_s = instr_valid & instr_ready;

  // NOP and zero-count repeats retire without ever issuing a strobe.
  assign skip_exec_s = ~in_cls_s &
                       ((in_fn_s == FN_NOP) | ((in_fn_s >= FN_INC) & (in_cnt_s == 4'd0)));

  assign alu_oc = fn_r;
  assign alu_a  = acc;
  assign alu_b  = arg_r;

  // State register, latched instruction fields and repeat counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cls_r   <= 1'b0;
      fn_r    <= 3'b000;
      arg_r   <= {WIDTH{1'b0}};
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        cls_r <= in_cls_s;
        fn_r  <= in_fn_s;
        arg_r <= in_arg_s;
        cnt_r <= in_cnt_s;
      end else if ((state_r == EXEC) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
    end
  end

  // Next-state and Moore output decode; at most one register strobe per EXEC cycle.
  always_comb begin
    state_nxt_s = state_r;
    instr_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    reg_cl      = 1'b0;
    reg_ld      = 1'b0;
    reg_inc     = 1'b0;
    reg_dec     = 1'b0;
    reg_sr      = 1'b0;
    reg_ir      = 1'b0;
    reg_sl      = 1'b0;
    reg_il      = 1'b0;
    reg_in      = {WIDTH{1'b0}};
    case (state_r)
      IDLE: begin
        instr_ready = rst_n;
        if (accept_s) begin
          state_nxt_s = skip_exec_s ? DONE : EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: begin
        busy = 1'b1;
        if (cls_r) begin
          reg_ld      = 1'b1;
          reg_in      = alu_f;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = (cnt_r == 4'd1) ? DONE : EXEC;
          case (fn_r)
            FN_LDI: begin
              reg_ld      = 1'b1;
              reg_in      = arg_r;
              state_nxt_s = DONE;
            end
            FN_CLR: begin
              reg_cl      = 1'b1;
              state_nxt_s = DONE;
            end
            FN_INC: reg_inc = 1'b1;
            FN_DEC: reg_dec = 1'b1;
            FN_SHR: reg_sr  = 1'b1;
            FN_SHL: reg_sl  = 1'b1;
            FN_ROR: begin
              reg_sr = 1'b1;
              reg_ir = acc[0];
            end
            default: state_nxt_s = DONE;
          endcase
        end
      end
      DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

endmodule

// File: tb/tb_acc_sequencer.sv
// Self-checking bench for acc_sequencer: a small ALU and register model close the
// feedback loop, a vector table covers each opcode, and hand sequences cover the corners.
module tb_acc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] acc;
  logic [3:0] alu_f;
  logic [2:0] alu_oc;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il;
  logic [3:0] reg_in;
  logic       busy;
  logic       done;
  logic [3:0] acc_m;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  acc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .acc(acc), .alu_f(alu_f), .alu_oc(alu_oc),
    .alu_a(alu_a), .alu_b(alu_b), .reg_cl(reg_cl), .reg_ld(reg_ld),
    .reg_inc(reg_inc), .reg_dec(reg_dec), .reg_sr(reg_sr), .reg_ir(reg_ir),
    .reg_sl(reg_sl), .reg_il(reg_il), .reg_in(reg_in), .busy(busy), .done(done)
  );

  // Bench ALU: 010 add, 001 subtract, anything else xor.
  always_comb begin
    case (alu_oc)
      3'b010:  alu_f = alu_a + alu_b;
      3'b001:  alu_f = alu_a - alu_b;
      default: alu_f = alu_a ^ alu_b;
    endcase
  end

  // Bench shift/count register driven by the strobes.
  always_ff @(posedge clk) begin
    if (!rst_n)       acc_m <= 4'd0;
    else if (reg_cl)  acc_m <= 4'd0;
    else if (reg_ld)  acc_m <= reg_in;
    else if (reg_inc) acc_m <= acc_m + 4'd1;
    else if (reg_dec) acc_m <= acc_m - 4'd1;
    else if (reg_sr)  acc_m <= {reg_ir, acc_m[3:1]};
    else if (reg_sl)  acc_m <= {acc_m[2:0], reg_il};
  end
  assign acc = acc_m;

  typedef struct {
    logic [7:0] instr;
    int         lat;
    logic [7:0] mask;
    int         nstr;
    logic [3:0] exp_in;
    logic [3:0] exp_acc;
  } vec_t;

  vec_t vecs[15];

  function automatic logic [7:0] strb();
    return {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_strobes"}, {24'd0, strb()}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_alu_oc"}, {29'd0, alu_oc}, 32'd0);
    chk({tag, "_alu_b"}, {28'd0, alu_b}, 32'd0);
    chk({tag, "_reg_in"}, {28'd0, reg_in}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] ins;
    logic       cls;
    logic [2:0] fn;
    logic [3:0] arg;
    logic       exp_ir;
    int         w;
    int         nstr;
    bit         got;
    ins  = v.instr;
    cls  = ins[7];
    fn   = ins[6:4];
    arg  = ins[3:0];
    w    = 0;
    nstr = 0;
    got  = 1'b0;
    while (!instr_ready && w < 10) begin
      tick();
      w++;
    end
    chk("ready_idle", {31'd0, instr_ready}, 32'd1);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    instr       = ins;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    instr       = 8'hFF;
    for (int k = 1; k <= 20; k++) begin
      if (done) begin
        chk("latency", k, v.lat);
        chk("done_strobes", {24'd0, strb()}, 32'd0);
        chk("done_busy", {31'd0, busy}, 32'd1);
        chk("done_ready", {31'd0, instr_ready}, 32'd0);
        chk("final_acc", {28'd0, acc_m}, {28'd0, v.exp_acc});
        got = 1'b1;
        break;
      end
      chk("exec_busy", {31'd0, busy}, 32'd1);
      chk("exec_ready", {31'd0, instr_ready}, 32'd0);
      chk("exec_mask", {24'd0, strb() & 8'hFB}, {24'd0, v.mask});
      if ((strb() & 8'hFB) != 8'h00) nstr++;
      exp_ir = (!cls && fn == 3'b111) ? acc_m[0] : 1'b0;
      chk("exec_ir", {31'd0, reg_ir}, {31'd0, exp_ir});
      if (reg_ld) chk("exec_reg_in", {28'd0, reg_in}, {28'd0, v.exp_in});
      if (cls) begin
        chk("alu_oc", {29'd0, alu_oc}, {29'd0, fn});
        chk("alu_b", {28'd0, alu_b}, {28'd0, arg});
        chk("alu_a", {28'd0, alu_a}, {28'd0, acc_m});
      end
      tick();
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
    chk("strobe_cycles", nstr, v.nstr);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    int ninc;
    int nld;
    int lat;
    bit got;
    vecs[0]  = '{8'h15, 2, 8'h40, 1, 4'h5, 4'h5};
    vecs[1]  = '{8'hA3, 2, 8'h40, 1, 4'h8, 4'h8};
    vecs[2]  = '{8'h1E, 2, 8'h40, 1, 4'hE, 4'hE};
    vecs[3]  = '{8'h33, 4, 8'h20, 3, 4'h0, 4'h1};
    vecs[4]  = '{8'h13, 2, 8'h40, 1, 4'h3, 4'h3};
    vecs[5]  = '{8'h71, 2, 8'h08, 1, 4'h0, 4'h9};
    vecs[6]  = '{8'h60, 1, 8'h00, 0, 4'h0, 4'h9};
    vecs[7]  = '{8'h00, 1, 8'h00, 0, 4'h0, 4'h9};
    vecs[8]  = '{8'h22, 2, 8'h80, 1, 4'h0, 4'h0};
    vecs[9]  = '{8'h44, 5, 8'h10, 4, 4'h0, 4'hC};
    vecs[10] = '{8'h52, 3, 8'h08, 2, 4'h0, 4'h3};
    vecs[11] = '{8'h62, 3, 8'h02, 2, 4'h0, 4'hC};
    vecs[12] = '{8'h73, 4, 8'h08, 3, 4'h0, 4'h9};
    vecs[13] = '{8'h81, 2, 8'h40, 1, 4'h8, 4'h8};
    vecs[14] = '{8'h92, 2, 8'h40, 1, 4'h6, 4'h6};

    rst_n       = 1'b0;
    instr       = 8'h00;
    instr_valid = 1'b0;
    tick();
    tick();
    chk_quiet("reset");
    chk("reset_ready", {31'd0, instr_ready}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_reset", {31'd0, instr_ready}, 32'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during the second EXEC cycle of DEC x5 abandons the instruction.
    instr       = 8'h45;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("abort_dec1", {31'd0, reg_dec}, 32'd1);
    tick();
    rst_n = 1'b0;
    tick();
    chk_quiet("abort");
    chk("abort_ready", {31'd0, instr_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("abort_ready_release", {31'd0, instr_ready}, 32'd1);
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      if (done || (strb() != 8'h00)) ndone++;
      tick();
    end
    chk("abort_no_activity", ndone, 0);

    // instr_valid held with changing instr while busy: only the accepted one runs.
    run_vec('{8'h10, 2, 8'h40, 1, 4'h0, 4'h0});
    instr       = 8'h32;
    instr_valid = 1'b1;
    tick();
    ninc = 0;
    lat  = 0;
    got  = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      instr = 8'h30 + 8'(k);
      if (done) begin
        lat = k;
        got = 1'b1;
        break;
      end
      chk("hold_ready", {31'd0, instr_ready}, 32'd0);
      if (reg_inc) ninc++;
      tick();
    end
    chk("hold_done_seen", {31'd0, got}, 32'd1);
    chk("hold_latency", lat, 3);
    chk("hold_inc_cycles", ninc, 2);
    chk("hold_acc", {28'd0, acc_m}, 32'd2);
    tick();
    chk("hold_ready_idle", {31'd0, instr_ready}, 32'd1);
    instr = 8'h11;
    tick();
    instr_valid = 1'b0;
    nld = 0;
    got = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (reg_ld) nld++;
      tick();
    end
    chk("hold2_done_seen", {31'd0, got}, 32'd1);
    chk("hold2_ld_cycles", nld, 1);
    chk("hold2_acc", {28'd0, acc_m}, 32'd1);
    tick();
    tick();
    chk("final_idle_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
